// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//
// Shares one ALU between two requesters. Requesters are accepted by a valid/ready
// handshake and granted round-robin. Each accepted operation goes through two
// register stages. Its result comes back as a one-cycle pulse on the requester's
// rsp_valid bit, two cycles after the accept. The pipeline never stalls, so up to
// one operation per cycle can be accepted.
//
// Ports:
//   clk                   rising-edge clock
//   reset                 synchronous active-high reset (has priority over flush)
//   flush                 synchronous kill of all in-flight operations
//   req_valid[1:0]        per-requester request valid
//   req_ready[1:0]        per-requester grant/accept (at most one bit high)
//   req_op0/1             ALU operation code per requester
//   req_a0/1, req_b0/1    SrcA / SrcB per requester
//   rsp_valid[1:0]        one-cycle result pulse, bit i = result for requester i
//   rsp_data              result, meaningful while any rsp_valid bit is high
//   busy                  either pipeline stage holds a live operation

module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [OPCODE_LENGTH-1:0] req_op0,
  input  logic [OPCODE_LENGTH-1:0] req_op1,
  input  logic [DATA_WIDTH-1:0]    req_a0,
  input  logic [DATA_WIDTH-1:0]    req_a1,
  input  logic [DATA_WIDTH-1:0]    req_b0,
  input  logic [DATA_WIDTH-1:0]    req_b1,
  output logic [1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     busy
);

  localparam logic [OPCODE_LENGTH-1:0] OpAnd = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OpOr  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OpAdd = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OpXor = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OpSub = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OpEq  = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OpLt  = OPCODE_LENGTH'(4'b1100);

  // Round-robin pointer: index of the requester that wins the next contention.
  logic prio_q, prio_d;
  logic prio_eff;

  // Arbiter outputs.
  logic [1:0] grant;
  logic       accept;
  logic       acc_id;

  // Operands of the accepted request.
  logic [OPCODE_LENGTH-1:0] acc_op;
  logic [DATA_WIDTH-1:0]    acc_a;
  logic [DATA_WIDTH-1:0]    acc_b;

  // Stage 1: registered operands feeding the ALU.
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_id_q;
  logic [OPCODE_LENGTH-1:0] s1_op_q;
  logic [DATA_WIDTH-1:0]    s1_a_q;
  logic [DATA_WIDTH-1:0]    s1_b_q;

  // Stage 2: registered result.
  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_id_q;
  logic [DATA_WIDTH-1:0] s2_result_q;

  logic [DATA_WIDTH-1:0] alu_result;

  // ---------------------------------------------------------------------------
  // Arbiter
  // ---------------------------------------------------------------------------

  // While reset is held the grant behaves as if the pointer were already cleared.
  // A request accepted on the reset edge is dropped anyway, so this only keeps
  // req_ready consistent from the first cycle of reset.
  assign prio_eff = reset ? 1'b0 : prio_q;

  always_comb begin
    grant = 2'b00;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_eff ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign acc_id    = grant[1];

  always_comb begin
    acc_op = req_op0;
    acc_a  = req_a0;
    acc_b  = req_b0;
    if (acc_id) begin
      acc_op = req_op1;
      acc_a  = req_a1;
      acc_b  = req_b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  always_comb begin
    prio_d = prio_q;
    if (accept) begin
      // The pointer moves even when flush discards the operation.
      prio_d = ~acc_id;
    end
    s1_valid_d = accept & ~flush;
    s2_valid_d = s1_valid_q & ~flush;
  end

  // ---------------------------------------------------------------------------
  // ALU (evaluated from stage 1)
  // ---------------------------------------------------------------------------

  always_comb begin
    alu_result = '0;
    case (s1_op_q)
      OpAnd:   alu_result = s1_a_q & s1_b_q;
      OpOr:    alu_result = s1_a_q | s1_b_q;
      OpAdd:   alu_result = s1_a_q + s1_b_q;
      OpXor:   alu_result = s1_a_q ^ s1_b_q;
      OpSub:   alu_result = s1_a_q - s1_b_q;
      OpEq:    alu_result = DATA_WIDTH'(s1_a_q == s1_b_q);
      OpLt:    alu_result = DATA_WIDTH'(s1_a_q < s1_b_q);
      default: alu_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------

  // Control state and the result register. Reset clears everything here, while
  // flush only clears the valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
    end else begin
      prio_q     <= prio_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_valid_q) begin
        s2_result_q <= alu_result;
      end
    end
  end

  // Data registers have no reset. They are only observed when their valid bit is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_id_q <= acc_id;
      s1_op_q <= acc_op;
      s1_a_q  <= acc_a;
      s1_b_q  <= acc_b;
    end
    if (s1_valid_q) begin
      s2_id_q <= s1_id_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  assign rsp_valid = s2_valid_q ? (2'b01 << s2_id_q) : 2'b00;
  assign rsp_data  = s2_result_q;
  assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a table of single-op vectors issued
// back to back, plus hand-written sequences for contention, fairness, flush and reset.

module tb_alu_share_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned OW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [OW-1:0] req_op0, req_op1;
  logic [DW-1:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          busy;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(
    .DATA_WIDTH   (DW),
    .OPCODE_LENGTH(OW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op0  (req_op0),
    .req_op1  (req_op1),
    .req_a0   (req_a0),
    .req_a1   (req_a1),
    .req_b0   (req_b0),
    .req_b1   (req_b1),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          id;
    logic [OW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vec [NV];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 2'b00;
    step();
    reset = 1'b0;
  endtask

  task automatic drive(input logic id, input logic [OW-1:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b);
    req_valid = id ? 2'b10 : 2'b01;
    if (id) begin
      req_op1 = op;
      req_a1  = a;
      req_b1  = b;
    end else begin
      req_op0 = op;
      req_a0  = a;
      req_b0  = b;
    end
  endtask

  initial begin
    vec[0]  = '{1'b0, 4'b0010, 32'd5,        32'd7,        32'd12};
    vec[1]  = '{1'b1, 4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0};
    vec[2]  = '{1'b0, 4'b0110, 32'd0,        32'd1,        32'hFFFFFFFF};
    vec[3]  = '{1'b1, 4'b1100, 32'hFFFFFFFF, 32'd1,        32'd0};
    vec[4]  = '{1'b0, 4'b1000, 32'd3,        32'd3,        32'd1};
    vec[5]  = '{1'b1, 4'b0101, 32'd9,        32'd9,        32'd0};
    vec[6]  = '{1'b0, 4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
    vec[7]  = '{1'b1, 4'b0001, 32'h0000F0F0, 32'h00000F00, 32'h0000FFF0};
    vec[8]  = '{1'b0, 4'b0011, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00};
    vec[9]  = '{1'b1, 4'b1100, 32'd1,        32'd2,        32'd1};
    vec[10] = '{1'b0, 4'b1000, 32'd3,        32'd4,        32'd0};
    vec[11] = '{1'b1, 4'b0110, 32'd10,       32'd3,        32'd7};

    reset = 1'b1; flush = 1'b0; req_valid = 2'b00;
    req_op0 = '0; req_op1 = '0; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;

    // Reset state
    step();
    check("reset_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    req_valid = 2'b11;
    #1;
    check("reset_ready_both", {30'b0, req_ready}, 32'd1);
    step();
    reset     = 1'b0;
    req_valid = 2'b00;
    step();

    // Single op with busy/latency
    drive(1'b0, 4'b0010, 32'd5, 32'd7);
    #1;
    check("single_ready", {30'b0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    check("single_busy_c1", {31'b0, busy}, 32'd1);
    check("single_rsp_c1", {30'b0, rsp_valid}, 32'd0);
    step();
    check("single_rsp_c2", {30'b0, rsp_valid}, 32'd1);
    check("single_data_c2", rsp_data, 32'd12);
    check("single_busy_c2", {31'b0, busy}, 32'd1);
    step();
    check("single_rsp_c3", {30'b0, rsp_valid}, 32'd0);
    check("single_busy_c3", {31'b0, busy}, 32'd0);

    // Table: one op per cycle, response checked two cycles after issue
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        drive(vec[i].id, vec[i].op, vec[i].a, vec[i].b);
        #1;
        check($sformatf("vec%0d_ready", i), {30'b0, req_ready},
              vec[i].id ? 32'd2 : 32'd1);
      end else begin
        req_valid = 2'b00;
      end
      step();
      if (i >= 1) begin
        check($sformatf("vec%0d_rsp_valid", i - 1), {30'b0, rsp_valid},
              vec[i - 1].id ? 32'd2 : 32'd1);
        check($sformatf("vec%0d_rsp_data", i - 1), rsp_data, vec[i - 1].exp);
      end
    end
    step();
    check("table_idle_rsp", {30'b0, rsp_valid}, 32'd0);
    check("table_idle_busy", {31'b0, busy}, 32'd0);

    // Contention: both valid for 4 cycles after reset -> grants 0,1,0,1
    do_reset();
    req_op0 = 4'b0010; req_a0 = 32'd1;  req_b0 = 32'd2;
    req_op1 = 4'b0010; req_a1 = 32'd10; req_b1 = 32'd20;
    for (int j = 0; j <= 4; j++) begin
      if (j < 4) begin
        req_valid = 2'b11;
        #1;
        check($sformatf("cont%0d_ready", j), {30'b0, req_ready}, (j % 2) ? 32'd2 : 32'd1);
      end else begin
        req_valid = 2'b00;
      end
      step();
      if (j >= 1) begin
        check($sformatf("cont%0d_rsp_valid", j - 1), {30'b0, rsp_valid},
              ((j - 1) % 2) ? 32'd2 : 32'd1);
        check($sformatf("cont%0d_rsp_data", j - 1), rsp_data,
              ((j - 1) % 2) ? 32'd30 : 32'd3);
      end
    end
    req_valid = 2'b00;
    step();

    // Fairness: 0 alone, then both -> 1; then 1 was served, so both -> 0
    drive(1'b0, 4'b0010, 32'd1, 32'd1);
    step();
    req_valid = 2'b11;
    #1;
    check("fair_after0", {30'b0, req_ready}, 32'd2);
    step();
    req_valid = 2'b00;
    step();
    drive(1'b1, 4'b0010, 32'd1, 32'd1);
    step();
    req_valid = 2'b11;
    #1;
    check("fair_after1", {30'b0, req_ready}, 32'd1);
    req_valid = 2'b00;
    step();
    step();
    step();

    // Flush: accepts in N and N+1, flush in N+1 -> no responses
    drive(1'b0, 4'b0010, 32'd1, 32'd1);
    step();
    drive(1'b1, 4'b0010, 32'd2, 32'd2);
    flush = 1'b1;
    #1;
    check("flush_ready", {30'b0, req_ready}, 32'd2);
    step();
    flush     = 1'b0;
    req_valid = 2'b00;
    check("flush_rsp_n2", {30'b0, rsp_valid}, 32'd0);
    check("flush_busy_n2", {31'b0, busy}, 32'd0);
    step();
    check("flush_rsp_n3", {30'b0, rsp_valid}, 32'd0);
    // Flushed accept of requester 1 still moved the pointer back to 0
    req_valid = 2'b11;
    req_op0 = 4'b0010; req_a0 = 32'd2; req_b0 = 32'd2;
    #1;
    check("flush_prio", {30'b0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    step();
    check("post_flush_rsp", {30'b0, rsp_valid}, 32'd1);
    check("post_flush_data", rsp_data, 32'd4);
    step();

    // Reset mid-stream
    drive(1'b0, 4'b0010, 32'd1, 32'd1);   // cycle A
    step();
    drive(1'b0, 4'b0010, 32'd5, 32'd5);   // cycle B, pointer now 1
    step();
    check("rst_mid_rsp_a", {30'b0, rsp_valid}, 32'd1);  // cycle C: op from A
    check("rst_mid_data_a", rsp_data, 32'd2);
    reset     = 1'b1;
    req_valid = 2'b11;
    req_op0 = 4'b0010; req_a0 = 32'd20; req_b0 = 32'd22;
    #1;
    check("rst_mid_ready_in_reset", {30'b0, req_ready}, 32'd1);
    step();
    reset = 1'b0;                          // cycle D
    #1;
    check("rst_mid_rsp_d", {30'b0, rsp_valid}, 32'd0);
    check("rst_mid_data_d", rsp_data, 32'd0);
    check("rst_mid_busy_d", {31'b0, busy}, 32'd0);
    check("rst_mid_prio", {30'b0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;                     // cycle E
    check("rst_mid_rsp_e", {30'b0, rsp_valid}, 32'd0);
    check("rst_mid_busy_e", {31'b0, busy}, 32'd1);
    step();                                // cycle F
    check("rst_mid_rsp_f", {30'b0, rsp_valid}, 32'd1);
    check("rst_mid_data_f", rsp_data, 32'd42);
    step();
    check("rst_mid_rsp_g", {30'b0, rsp_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-port arbiter and pipeline sequencer that shares one ALU datapath between two requesters, such as the execute stage and the branch-compare/address unit. Requests are accepted by valid/ready handshake and granted round-robin. The block registers operands, drives the ALU, and returns each result to the originating requester as a single-cycle response pulse. Sustained throughput is one operation per cycle with fixed 2-cycle latency.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU operation code width

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- flush  input  1  synchronous kill of all in-flight operations
- req_valid  input  2  per-requester request valid; bit i = requester i
- req_ready  output  2  per-requester grant/accept; at most one bit high
- req_op0, req_op1  input  OPCODE_LENGTH  operation code per requester
- req_a0, req_a1  input  DATA_WIDTH  SrcA per requester
- req_b0, req_b1  input  DATA_WIDTH  SrcB per requester
- rsp_valid  output  2  one-cycle result pulse; bit i = result for requester i
- rsp_data  output  DATA_WIDTH  result, valid when any rsp_valid bit is high
- busy  output  1  high when either pipeline stage holds a live operation

## Operation
- ALU op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 1000 EQ (1 if A==B), 1100 LT (unsigned, 1 if A<B). Any other code gives result 0; it is still accepted and still returns a response.
- Arithmetic wraps modulo 2^DATA_WIDTH. Compare results are zero-extended to DATA_WIDTH.
- Arbitration is combinational from req_valid and the priority pointer prio (1 bit):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester indexed by prio is granted.
  - req_ready is low for both when neither is valid.
  - req_ready never depends on downstream state; the pipeline never stalls.
- Handshake: accepted at a rising edge where req_valid[i] && req_ready[i].
  - Requester holds op/a/b stable while valid and not ready.
  - Requester may drop valid without an accept; no penalty.
- On accept:
  - prio <= ~granted index, so the other requester wins the next contention.
  - prio is unchanged in cycles without an accept.
- Stage 1 register: s1_valid, s1_id, s1_op, s1_a, s1_b. ALU evaluates combinationally from stage 1.
- Stage 2 register: s2_valid, s2_id, s2_result. rsp_valid = s2_valid ? (1 << s2_id) : 0. rsp_data = s2_result.
- flush:
  - clears s1_valid and s2_valid at that edge.
  - An accept in the same cycle still completes its handshake, but the operation is discarded and prio still updates.
  - Data registers are not cleared.
- busy = s1_valid | s2_valid.

## Timing
- Accept at the edge ending cycle N → operands in stage 1 during N+1 → rsp_valid[id] high during N+2 only. Latency is 2 cycles.
- Back-to-back accepts on consecutive edges give responses on consecutive cycles, in acceptance order.
- Reset values: prio=0, s1_valid=0, s2_valid=0, s2_result=0, so rsp_valid=00, rsp_data=0, busy=0.
- req_ready during reset follows the arbiter function with prio=0. Requests accepted on a reset edge are discarded.
- Reset or flush mid-operation: no response is ever produced for operations in flight at that edge.
- reset has priority over flush. Both clear the valid bits identically; only reset clears prio and s2_result.

## Test plan
- Single op: req_valid=01, op=0010, a0=5, b0=7 for one accept → rsp_valid=01, rsp_data=12 exactly 2 cycles later, one cycle wide; busy high for 2 cycles.
- Wrap/compare: ADD 0xFFFFFFFF+1 → 0. SUB 0−1 → 0xFFFFFFFF. LT 0xFFFFFFFF<1 → 0. EQ 3==3 → 1. Op 0101 → response with data 0.
- Contention: req_valid=11 held for 4 cycles after reset → grants 0,1,0,1; responses alternate rsp_valid=01/10 with the correct per-requester data.
- Fairness after idle: requester 1 alone accepted once, then both valid → requester 0 granted next.
- Flush: accept ops in cycles N and N+1, flush in N+1 → no rsp_valid in N+2 or N+3; next accepted op responds normally.
- Reset mid-stream: continuous accepts, reset asserted one cycle → rsp_valid stays 00 until 2 cycles after the first post-reset accept; prio back to 0.
